// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Power-up and recovery controller for the core clock-generator PLL. It runs
// on the board reference clock, which is valid before the PLL locks. The
// block pulses the PLL reset, waits for lock and retries a PLL that does not
// lock in time. It releases the core reset only after lock has been stable
// for STABLE_CYCLES consecutive cycles. The core can restart the whole
// sequence with a one-cycle req_reset pulse, e.g. on a video-mode change.
//
// Optional feature, selected with the macro PLL_LOSS_RECOVER_EN:
//   defined   - loss of lock in RUN sets lock_lost and restarts the sequence
//               (sys_reset reasserts on the same edge).
//   undefined - loss of lock in RUN only sets lock_lost; the core stays out
//               of reset and decides itself whether to issue req_reset.
//
// Ports:
//   refclk     in   reference clock (50 MHz)
//   rst        in   asynchronous active-high reset; clears every flop
//   pll_locked in   PLL lock indication, asynchronous to refclk
//   req_reset  in   1-cycle pulse, restarts the sequence from RESET_PLL
//   pll_rst    out  PLL reset input
//   sys_reset  out  active-high core reset
//   ready      out  high while in RUN (always ~sys_reset)
//   fail       out  high while in FAILED
//   retry_cnt  out  retries consumed in the current sequence
//   lock_lost  out  sticky flag, set on loss of lock in RUN; only rst clears it
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       req_reset,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic       lock_lost
);

  // One shared counter; it only ever has to reach (longest interval - 1).
  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAILED
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [3:0]       retry_nxt;
  logic             lost_nxt;
  logic             pll_rst_nxt, sys_reset_nxt, ready_nxt, fail_nxt;

  logic lock_sync_p0, lock_sync_p1;
  logic locked_s;

  assign locked_s = lock_sync_p1;

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_sync_p0 <= 1'b0;
      lock_sync_p1 <= 1'b0;
    end else begin
      lock_sync_p0 <= pll_locked;
      lock_sync_p1 <= lock_sync_p0;
    end
  end

  // ---- state register and registered outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= 4'd0;
      lock_lost <= 1'b0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      fail      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      lock_lost <= lost_nxt;
      pll_rst   <= pll_rst_nxt;
      sys_reset <= sys_reset_nxt;
      ready     <= ready_nxt;
      fail      <= fail_nxt;
    end
  end

  // ---- next-state logic; cnt is zero on entry to every state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost;

    if (req_reset) begin
      // Restart wins over timeout, lock loss and everything else.
      state_nxt = S_RESET_PLL;
      retry_nxt = 4'd0;
    end else begin
      case (state)
        S_RESET_PLL: begin
          // Lock is meaningless while the PLL is held in reset.
          if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
          else                 cnt_nxt   = cnt + CNT_W'(1);
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_STABLE;
          end else if (cnt == TIMEOUT_LAST) begin
            if (retry_cnt == RETRY_LIMIT) begin
              state_nxt = S_FAILED;
            end else begin
              state_nxt = S_RESET_PLL;
              retry_nxt = retry_cnt + 4'd1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_STABLE: begin
          // A single unlocked cycle restarts the lock timeout from scratch.
          if (!locked_s)                state_nxt = S_WAIT_LOCK;
          else if (cnt == STABLE_LAST)  state_nxt = S_RUN;
          else                          cnt_nxt   = cnt + CNT_W'(1);
        end
        S_RUN: begin
          if (!locked_s) begin
            lost_nxt = 1'b1;
`ifdef PLL_LOSS_RECOVER_EN
            state_nxt = S_RESET_PLL;
            retry_nxt = 4'd0;
`endif
          end
        end
        S_FAILED: begin
          state_nxt = S_FAILED;
        end
        default: begin
          state_nxt = S_RESET_PLL;
          retry_nxt = 4'd0;
        end
      endcase
    end

    // Outputs decoded from the next state so they move with the state.
    pll_rst_nxt   = (state_nxt == S_RESET_PLL) || (state_nxt == S_FAILED);
    sys_reset_nxt = (state_nxt != S_RUN);
    ready_nxt     = (state_nxt == S_RUN);
    fail_nxt      = (state_nxt == S_FAILED);
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Directed scenarios followed by a randomized lock/req_reset phase. A
// timestamp-based reference model (phase + edge number at phase entry)
// predicts every output on every refclk edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int STABLE_CYCLES = 8;
  localparam int MAX_RETRY     = 2;

  localparam int PH_RST    = 10;
  localparam int PH_WAIT   = 11;
  localparam int PH_STABLE = 12;
  localparam int PH_RUN    = 13;
  localparam int PH_FAILED = 14;

  logic       refclk;
  logic       rst;
  logic       pll_locked;
  logic       req_reset;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       fail;
  logic [3:0] retry_cnt;
  logic       lock_lost;

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .MAX_RETRY    (MAX_RETRY)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .pll_locked(pll_locked),
    .req_reset (req_reset),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .lock_lost (lock_lost)
  );

  initial refclk = 1'b0;
  always #10 refclk = ~refclk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int m_phase;
  int m_start;   // edge number at which the current phase was entered
  int m_retry;
  bit m_lost;
  bit m_s1;
  bit m_ls;
  int cyc;

  int t_a, t_b, guard, hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [8:0] model_vec();
    logic pr, sr, rd, fl;
    pr = (m_phase == PH_RST) || (m_phase == PH_FAILED);
    sr = (m_phase != PH_RUN);
    rd = (m_phase == PH_RUN);
    fl = (m_phase == PH_FAILED);
    return {pr, sr, rd, fl, 4'(m_retry), m_lost};
  endfunction

  task automatic model_reset();
    m_phase = PH_RST;
    m_start = 0;
    m_retry = 0;
    m_lost  = 1'b0;
    m_s1    = 1'b0;
    m_ls    = 1'b0;
    cyc     = 0;
  endtask

  // Advance the model by one edge, wait for that edge, then compare.
  task automatic tick();
    int n;
    n = cyc + 1;
    if (req_reset) begin
      m_phase = PH_RST;
      m_start = n;
      m_retry = 0;
    end else begin
      case (m_phase)
        PH_RST: begin
          if (n - m_start == RST_CYCLES) begin
            m_phase = PH_WAIT;
            m_start = n;
          end
        end
        PH_WAIT: begin
          if (m_ls) begin
            m_phase = PH_STABLE;
            m_start = n;
          end else if (n - m_start == LOCK_TIMEOUT) begin
            if (m_retry == MAX_RETRY) m_phase = PH_FAILED;
            else begin
              m_retry = m_retry + 1;
              m_phase = PH_RST;
            end
            m_start = n;
          end
        end
        PH_STABLE: begin
          if (!m_ls) begin
            m_phase = PH_WAIT;
            m_start = n;
          end else if (n - m_start == STABLE_CYCLES) begin
            m_phase = PH_RUN;
            m_start = n;
          end
        end
        PH_RUN: begin
          if (!m_ls) begin
            m_lost = 1'b1;
`ifdef PLL_LOSS_RECOVER_EN
            m_phase = PH_RST;
            m_start = n;
            m_retry = 0;
`endif
          end
        end
        default: ;
      endcase
    end
    m_ls = m_s1;
    m_s1 = pll_locked;
    @(posedge refclk);
    cyc = n;
    #1;
    chk($sformatf("outputs_edge%0d", cyc),
        32'({pll_rst, sys_reset, ready, fail, retry_cnt, lock_lost}),
        32'(model_vec()));
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b1;
    req_reset  = 1'b0;
    model_reset();

    // Reset values while rst is held
    repeat (3) @(posedge refclk);
    #5;
    chk("reset_values", 32'({pll_rst, sys_reset, ready, fail, retry_cnt, lock_lost}),
        32'(9'b1_1_0_0_0000_0));
    rst = 1'b0;
    model_reset();

    // 1: lock already present -> pll_rst falls at edge 4, ready at edge 13
    t_a = 0;
    t_b = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (t_a == 0 && pll_rst === 1'b0) t_a = k;
      if (t_b == 0 && ready === 1'b1) t_b = k;
    end
    chk("t1_pll_rst_fall_edge", 32'(t_a), 32'(RST_CYCLES));
    chk("t1_ready_edge", 32'(t_b), 32'(RST_CYCLES + 1 + STABLE_CYCLES));
    chk("t1_retry_cnt", 32'(retry_cnt), 32'd0);

    // 4: lock loss in RUN
    pll_locked = 1'b0;
    repeat (3) tick();
    chk("t4_lock_lost", 32'(lock_lost), 32'd1);
`ifdef PLL_LOSS_RECOVER_EN
    chk("t4_sys_reset_reasserted", 32'(sys_reset), 32'd1);
`else
    chk("t4_ready_kept", 32'(ready), 32'd1);
`endif

    // 2: no lock at all -> three attempts, then FAILED
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    t_a = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (t_a == 0 && fail === 1'b1) t_a = k;
    end
    chk("t2_fail_edge", 32'(t_a), 32'((MAX_RETRY + 1) * (RST_CYCLES + LOCK_TIMEOUT)));
    chk("t2_fail_retry_cnt", 32'(retry_cnt), 32'(MAX_RETRY));
    chk("t2_fail_pll_rst", 32'(pll_rst), 32'd1);
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    chk("t2_req_fail", 32'(fail), 32'd0);
    chk("t2_req_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("t2_req_pll_rst", 32'(pll_rst), 32'd1);

    // 3: one timeout (retry_cnt=1), then a one-cycle lock glitch in STABLE
    repeat (RST_CYCLES + LOCK_TIMEOUT) tick();
    chk("t3_retry_after_timeout", 32'(retry_cnt), 32'd1);
    pll_locked = 1'b1;
    guard = 0;
    while (m_phase != PH_STABLE && guard < 40) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    t_b = 0;
    for (int k = 2; k <= 30; k++) begin
      tick();
      if (t_b == 0 && ready === 1'b1) t_b = k;
    end
    chk("t3_ready_edge_after_glitch", 32'(t_b), 32'(4 + STABLE_CYCLES));
    chk("t3_retry_unchanged", 32'(retry_cnt), 32'd1);

    // 5: req_reset in the same cycle as the WAIT_LOCK timeout
    pll_locked = 1'b0;
    repeat (3) tick();
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    repeat (RST_CYCLES + LOCK_TIMEOUT - 1) tick();
    req_reset = 1'b1;
    tick();
    req_reset = 1'b0;
    chk("t5_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("t5_pll_rst", 32'(pll_rst), 32'd1);

    // 6: asynchronous reset in the middle of STABLE
    pll_locked = 1'b1;
    req_reset  = 1'b1;
    tick();
    req_reset = 1'b0;
    guard = 0;
    while (m_phase != PH_STABLE && guard < 40) begin
      tick();
      guard++;
    end
    repeat (2) tick();
    #3;
    rst = 1'b1;
    #1;
    chk("t6_async_reset_values",
        32'({pll_rst, sys_reset, ready, fail, retry_cnt, lock_lost}),
        32'(9'b1_1_0_0_0000_0));
    repeat (2) @(posedge refclk);
    #5;
    rst = 1'b0;
    model_reset();

    // Randomized lock behaviour with occasional restart requests
    hold = 0;
    for (int i = 0; i < 800; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 99) < 70);
        hold = int'($urandom_range(1, 30));
      end
      hold--;
      req_reset = ($urandom_range(0, 79) == 0);
      tick();
    end
    req_reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Power-up and recovery controller for the core's clock-generator PLL.
- Runs on the 50 MHz board reference clock, which is valid before the PLL locks.
- Drives the PLL reset, watches the PLL lock output, and retries a PLL that fails to lock.
- Releases the core-wide reset only after lock has been stable for a programmable time.
- Accepts a soft re-sequence request from the core, e.g. a video-mode change.

Parameters:
- RST_CYCLES, 16: refclk cycles that pll_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 50000: refclk cycles to wait for lock before retrying (1 ms at 50 MHz; ≥2).
- STABLE_CYCLES, 1024: consecutive locked cycles required before release (≥1).
- MAX_RETRY, 7: retries after the first attempt before declaring failure (0..15).

Ports:
- refclk  in  1  reference clock, 50 MHz.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL lock indication; asynchronous to refclk.
- req_reset  in  1  synchronous to refclk; 1-cycle pulse restarts the sequence.
- pll_rst  out  1  drives the PLL reset input.
- sys_reset  out  1  active-high core reset.
- ready  out  1  high while in RUN; equals ~sys_reset.
- fail  out  1  high while in FAILED.
- retry_cnt  out  4  retries consumed in the current sequence.
- lock_lost  out  1  sticky flag; set on loss of lock in RUN.

Behaviour:
- Interface: one clock, refclk. Reset is asynchronous and active-high on port rst; all flops clear on rst assertion.
- Reset values:
  - pll_rst=1, sys_reset=1, ready=0, fail=0.
  - retry_cnt=0, lock_lost=0.
  - state=RESET_PLL, cnt=0.
- pll_locked passes through a 2-flop synchronizer (reset value 0) to form locked_s. All decisions use locked_s.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- cnt is a single counter, cleared on every state entry. It is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).
- States:
  - RESET_PLL: pll_rst=1, sys_reset=1. After RST_CYCLES cycles in the state → WAIT_LOCK. locked_s is ignored here.
  - WAIT_LOCK: pll_rst=0, sys_reset=1.
    - locked_s=1 → STABLE.
    - Else when cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRY → FAILED; otherwise retry_cnt+1 → RESET_PLL.
  - STABLE: pll_rst=0, sys_reset=1.
    - locked_s=0 → WAIT_LOCK, with the timeout restarted; retry_cnt is unchanged.
    - STABLE_CYCLES consecutive cycles with locked_s=1 → RUN.
  - RUN: pll_rst=0, sys_reset=0, ready=1. Behaviour on locked_s=0 depends on the optional feature below.
  - FAILED: pll_rst=1, fail=1, sys_reset=1. Left only by req_reset or rst.
- req_reset: in any state it clears retry_cnt and cnt and enters RESET_PLL on the next edge.
  - It has priority over every other transition in the same cycle, including timeout and lock loss.
  - lock_lost is not cleared by req_reset; only rst clears it.
- Nominal latency with the lock already present: ready rises RST_CYCLES+1+STABLE_CYCLES edges after the first edge following rst deassertion.
- Lock loss during pll_rst=1 is irrelevant, since locked_s is ignored in RESET_PLL.

Optional Feature:
- Macro: PLL_LOSS_RECOVER_EN.
- Defined: in RUN, locked_s=0 sets lock_lost, sets retry_cnt=0 and enters RESET_PLL on the next edge. sys_reset reasserts on that same edge.
- Undefined: in RUN, locked_s=0 only sets lock_lost. The state stays in RUN and sys_reset stays 0. Software or the core decides whether to issue req_reset.

Test Plan:
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=2.
1. pll_locked tied 1, rst released → pll_rst falls after edge 4; sys_reset falls and ready rises exactly at edge 13; retry_cnt=0.
2. pll_locked tied 0 → three attempts, each 4 cycles of pll_rst=1 then 20 cycles of wait; retry_cnt steps 1, 2. After the third timeout, fail=1 and pll_rst=1 with retry_cnt=2. A req_reset pulse then gives fail=0, retry_cnt=0 and pll_rst=1.
3. Lock rises, then drops for 1 cycle after 5 STABLE cycles → back to WAIT_LOCK. After lock returns, ready rises only after 8 fresh consecutive locked cycles; retry_cnt is unchanged.
4. In RUN, drop pll_locked:
   - With PLL_LOSS_RECOVER_EN: lock_lost=1 and sys_reset=1 two to three edges later, then a full re-sequence.
   - Without it: lock_lost=1, ready stays 1.
5. req_reset asserted in the same cycle as the WAIT_LOCK timeout → RESET_PLL with retry_cnt=0, not 1.
6. Assert rst asynchronously mid-STABLE → all outputs return to reset values without waiting for a refclk edge.
